// File: rtl/debug_dump_collector_pkg.sv
// ----------------------------------------------------------------------------
// debug_dump_collector_pkg
//  Definitions shared between the MIPS debug unit that emits the dump and the
//  host-side logic that collects it.
//  Contents:
//   - Section codes SEC_PC / SEC_REG / SEC_MEM, as seen on o_wr_section.
//   - Collector FSM state encodings (dump_state_t).
//   - Elaboration-time helpers for deriving counter widths.
// ----------------------------------------------------------------------------
package debug_dump_collector_pkg;

   // Section tags carried with every assembled word
   localparam logic [1:0] SEC_PC  = 2'd0;
   localparam logic [1:0] SEC_REG = 2'd1;
   localparam logic [1:0] SEC_MEM = 2'd2;

   // Collector states; PC/REG/MEM follow the order the dump is streamed in
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PC   = 3'd1,
      ST_REG  = 3'd2,
      ST_MEM  = 3'd3,
      ST_DONE = 3'd4
   } dump_state_t;

   // Ceiling log2; clog2(0) and clog2(1) both return 0
   function automatic int clog2(input int value);
      int result;
      int remaining;
      result    = 0;
      remaining = value - 1;
      while (remaining > 0) begin
         result    = result + 1;
         remaining = remaining >> 1;
      end
      return result;
   endfunction

   // Bits needed to hold values 0..n-1, never less than one bit
   function automatic int width_for(input int n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction

   // Largest of three section sizes
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/debug_dump_collector_byte_word_packer.sv
// ----------------------------------------------------------------------------
// byte_word_packer
//  Shifts UART bytes into a word, little-endian: the first byte of a word ends
//  up in bits [BYTE_WIDTH-1:0]. When the last byte of a word is accepted the
//  full word is registered on word_data and word_valid pulses for one cycle.
//  Ports:
//   i_clock, i_reset_n  clock, asynchronous active-low reset
//   clear               discard any partial word (takes priority over bytes)
//   byte_valid          one-cycle strobe: accept byte_data
//   byte_data           incoming byte
//   word_last           the next accepted byte completes a word
//   word_valid          one-cycle strobe: word_data holds a new word
//   word_data           last completed word, held between strobes
// ----------------------------------------------------------------------------
module byte_word_packer
   import debug_dump_collector_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int BYTE_WIDTH = 8
) (
   input  logic                  i_clock,
   input  logic                  i_reset_n,
   input  logic                  clear,
   input  logic                  byte_valid,
   input  logic [BYTE_WIDTH-1:0] byte_data,
   output logic                  word_last,
   output logic                  word_valid,
   output logic [DATA_WIDTH-1:0] word_data
);

   localparam int BPW   = DATA_WIDTH / BYTE_WIDTH;
   localparam int CNT_W = width_for(BPW);

   logic [DATA_WIDTH-1:0] shift_reg;
   logic [DATA_WIDTH-1:0] shifted;
   logic [CNT_W-1:0]      byte_count;

   // New bytes enter at the top and older bytes move down, so after BPW
   // bytes the first one sits in the least significant lane.
   generate
      if (BPW == 1) begin : g_single_byte
         assign shifted = byte_data;
      end else begin : g_multi_byte
         assign shifted = {byte_data, shift_reg[DATA_WIDTH-1:BYTE_WIDTH]};
      end
   endgenerate

   assign word_last = (byte_count == CNT_W'(BPW - 1));

   // Byte accumulation; the completed word is captured straight from the
   // shift path so the strobe lands one cycle after the final byte.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         shift_reg  <= '0;
         byte_count <= '0;
         word_valid <= 1'b0;
         word_data  <= '0;
      end else begin
         word_valid <= 1'b0;
         if (clear) begin
            shift_reg  <= '0;
            byte_count <= '0;
         end else if (byte_valid) begin
            if (word_last) begin
               word_data  <= shifted;
               word_valid <= 1'b1;
               shift_reg  <= '0;
               byte_count <= '0;
            end else begin
               shift_reg  <= shifted;
               byte_count <= byte_count + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/debug_dump_collector.sv
// ----------------------------------------------------------------------------
// debug_dump_collector
//  Reassembles the MIPS debug dump (PC, register file, data memory) arriving
//  byte by byte from the UART receiver into words, and presents each word on
//  a write port tagged with its section and index within that section.
//  Ports:
//   i_clock, i_reset_n   clock, asynchronous active-low reset
//   i_start              arm / restart collection (1-cycle pulse)
//   i_abort              return to IDLE, discarding any partial word
//   i_rx_done, i_rx_data UART byte-valid level and byte
//   o_wr_en              1-cycle strobe: word complete
//   o_wr_section         SEC_PC / SEC_REG / SEC_MEM
//   o_wr_index           word index within the section
//   o_wr_data            assembled word, held between strobes
//   o_busy               collecting (PC/REG/MEM states)
//   o_done               whole dump collected
//   o_error              sticky inter-byte timeout, cleared by i_start
// ----------------------------------------------------------------------------
module debug_dump_collector
   import debug_dump_collector_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int BYTE_WIDTH     = 8,
   parameter int PC_WORDS       = 1,
   parameter int REG_WORDS      = 32,
   parameter int MEM_WORDS      = 32,
   parameter int TIMEOUT_CYCLES = 0,
   localparam int IDX_W = width_for(max3(PC_WORDS, REG_WORDS, MEM_WORDS) + 1)
) (
   input  logic                  i_clock,
   input  logic                  i_reset_n,
   input  logic                  i_start,
   input  logic                  i_abort,
   input  logic                  i_rx_done,
   input  logic [BYTE_WIDTH-1:0] i_rx_data,
   output logic                  o_wr_en,
   output logic [1:0]            o_wr_section,
   output logic [IDX_W-1:0]      o_wr_index,
   output logic [DATA_WIDTH-1:0] o_wr_data,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_error
);

   localparam int TO_W = width_for(TIMEOUT_CYCLES + 1);

   dump_state_t      state;
   dump_state_t      start_state;
   dump_state_t      next_section;
   logic [IDX_W-1:0] index;
   logic [TO_W-1:0]  timeout_cnt;
   logic             rx_done_prev;
   logic             state_busy;
   logic             rx_edge;
   logic             accept;
   logic             word_last;
   logic             timeout_hit;
   logic             packer_clear;

   // Section that follows 'cur', skipping empty sections. From IDLE or DONE
   // this yields the first section to collect.
   function automatic dump_state_t section_after(input dump_state_t cur);
      dump_state_t nxt;
      nxt = ST_DONE;
      case (cur)
         ST_IDLE, ST_DONE: begin
            if (PC_WORDS > 0)       nxt = ST_PC;
            else if (REG_WORDS > 0) nxt = ST_REG;
            else if (MEM_WORDS > 0) nxt = ST_MEM;
         end
         ST_PC: begin
            if (REG_WORDS > 0)      nxt = ST_REG;
            else if (MEM_WORDS > 0) nxt = ST_MEM;
         end
         ST_REG: begin
            if (MEM_WORDS > 0)      nxt = ST_MEM;
         end
         default: nxt = ST_DONE;
      endcase
      return nxt;
   endfunction

   // Index of the final word in the section being collected
   function automatic logic [IDX_W-1:0] last_index(input dump_state_t cur);
      logic [IDX_W-1:0] last;
      case (cur)
         ST_PC:   last = IDX_W'(PC_WORDS - 1);
         ST_REG:  last = IDX_W'(REG_WORDS - 1);
         ST_MEM:  last = IDX_W'(MEM_WORDS - 1);
         default: last = '0;
      endcase
      return last;
   endfunction

   function automatic logic [1:0] section_code(input dump_state_t cur);
      logic [1:0] code;
      case (cur)
         ST_REG:  code = SEC_REG;
         ST_MEM:  code = SEC_MEM;
         default: code = SEC_PC;
      endcase
      return code;
   endfunction

   function automatic logic is_busy(input dump_state_t cur);
      return (cur == ST_PC) || (cur == ST_REG) || (cur == ST_MEM);
   endfunction

   assign start_state  = section_after(ST_IDLE);
   assign next_section = section_after(state);
   assign state_busy   = is_busy(state);

   // A held-high i_rx_done only counts once: bytes are taken on its rising
   // edge, and only while a section is being collected. i_start and i_abort
   // both discard the byte arriving alongside them.
   assign rx_edge = i_rx_done && !rx_done_prev;
   assign accept  = rx_edge && state_busy && !i_abort && !i_start;

   // The idle counter restarts on every accepted byte, so a timeout only
   // fires in a cycle with no byte.
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && state_busy && !accept &&
                        (timeout_cnt == TO_W'(TIMEOUT_CYCLES - 1));

   assign packer_clear = i_abort || i_start || timeout_hit;

   byte_word_packer #(
      .DATA_WIDTH (DATA_WIDTH),
      .BYTE_WIDTH (BYTE_WIDTH)
   ) u_packer (
      .i_clock    (i_clock),
      .i_reset_n  (i_reset_n),
      .clear      (packer_clear),
      .byte_valid (accept),
      .byte_data  (i_rx_data),
      .word_last  (word_last),
      .word_valid (o_wr_en),
      .word_data  (o_wr_data)
   );

   // Section FSM with index and timeout counters. The section/index tag is
   // captured on the same edge the packer registers the word, so tag and
   // data line up with the o_wr_en strobe. Abort beats start; start beats
   // everything else, including a byte completing a word.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state        <= ST_IDLE;
         index        <= '0;
         timeout_cnt  <= '0;
         rx_done_prev <= 1'b0;
         o_wr_section <= '0;
         o_wr_index   <= '0;
         o_busy       <= 1'b0;
         o_done       <= 1'b0;
         o_error      <= 1'b0;
      end else begin
         rx_done_prev <= i_rx_done;
         if (i_abort) begin
            state       <= ST_IDLE;
            index       <= '0;
            timeout_cnt <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
         end else if (i_start) begin
            state       <= start_state;
            index       <= '0;
            timeout_cnt <= '0;
            o_busy      <= is_busy(start_state);
            o_done      <= (start_state == ST_DONE);
            o_error     <= 1'b0;
         end else if (state_busy) begin
            if (accept) begin
               timeout_cnt <= '0;
               if (word_last) begin
                  o_wr_section <= section_code(state);
                  o_wr_index   <= index;
                  if (index == last_index(state)) begin
                     state  <= next_section;
                     index  <= '0;
                     o_busy <= is_busy(next_section);
                     o_done <= (next_section == ST_DONE);
                  end else begin
                     index <= index + IDX_W'(1);
                  end
               end
            end else if (timeout_hit) begin
               state       <= ST_IDLE;
               index       <= '0;
               timeout_cnt <= '0;
               o_busy      <= 1'b0;
               o_error     <= 1'b1;
            end else if (TIMEOUT_CYCLES != 0) begin
               timeout_cnt <= timeout_cnt + TO_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_debug_dump_collector.sv
// ----------------------------------------------------------------------------
// tb_debug_dump_collector
//  Directed bench for debug_dump_collector. Three instances share the input
//  stimulus: the default full-dump configuration, one with a 100-cycle
//  timeout, and a register-only (2 words) configuration.
// ----------------------------------------------------------------------------
module tb_debug_dump_collector;

   logic        clock;
   logic        reset_n;
   logic        start;
   logic        abort;
   logic        rx_done;
   logic [7:0]  rx_data;

   logic        wr_en,   wr_en_to,   wr_en_s;
   logic [1:0]  wr_sec,  wr_sec_to,  wr_sec_s;
   logic [5:0]  wr_idx,  wr_idx_to;
   logic [1:0]  wr_idx_s;
   logic [31:0] wr_data, wr_data_to, wr_data_s;
   logic        busy,    busy_to,    busy_s;
   logic        done,    done_to,    done_s;
   logic        error,   error_to,   error_s;

   int tests_run;
   int tests_failed;

   int          cnt_main;
   logic [1:0]  last_sec;
   logic [5:0]  last_idx;
   logic [31:0] last_data;
   int          cnt_to;
   int          cnt_s;
   logic [1:0]  last_sec_s;
   logic [1:0]  last_idx_s;

   debug_dump_collector dut (
      .i_clock (clock), .i_reset_n (reset_n), .i_start (start), .i_abort (abort),
      .i_rx_done (rx_done), .i_rx_data (rx_data),
      .o_wr_en (wr_en), .o_wr_section (wr_sec), .o_wr_index (wr_idx),
      .o_wr_data (wr_data), .o_busy (busy), .o_done (done), .o_error (error)
   );

   debug_dump_collector #(.TIMEOUT_CYCLES(100)) dut_to (
      .i_clock (clock), .i_reset_n (reset_n), .i_start (start), .i_abort (abort),
      .i_rx_done (rx_done), .i_rx_data (rx_data),
      .o_wr_en (wr_en_to), .o_wr_section (wr_sec_to), .o_wr_index (wr_idx_to),
      .o_wr_data (wr_data_to), .o_busy (busy_to), .o_done (done_to), .o_error (error_to)
   );

   debug_dump_collector #(.PC_WORDS(0), .REG_WORDS(2), .MEM_WORDS(0)) dut_s (
      .i_clock (clock), .i_reset_n (reset_n), .i_start (start), .i_abort (abort),
      .i_rx_done (rx_done), .i_rx_data (rx_data),
      .o_wr_en (wr_en_s), .o_wr_section (wr_sec_s), .o_wr_index (wr_idx_s),
      .o_wr_data (wr_data_s), .o_busy (busy_s), .o_done (done_s), .o_error (error_s)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Record every strobe mid-cycle, away from the active edge
   always @(negedge clock) begin
      if (wr_en) begin
         cnt_main  <= cnt_main + 1;
         last_sec  <= wr_sec;
         last_idx  <= wr_idx;
         last_data <= wr_data;
      end
      if (wr_en_to) cnt_to <= cnt_to + 1;
      if (wr_en_s) begin
         cnt_s      <= cnt_s + 1;
         last_sec_s <= wr_sec_s;
         last_idx_s <= wr_idx_s;
      end
   end

   // Global guard so the bench can never hang
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // All stimulus tasks start and end 1 time unit after a rising edge
   task automatic send_byte(input logic [7:0] b, input int hold);
      rx_data = b;
      rx_done = 1'b1;
      repeat (hold) @(posedge clock);
      #1 rx_done = 1'b0;
      @(posedge clock);
      #1;
   endtask

   task automatic send_word(input logic [31:0] w, input int hold);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], hold);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
   endtask

   task automatic pulse_abort();
      abort = 1'b1;
      @(posedge clock);
      #1 abort = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clock);
      #1 reset_n = 1'b1;
      @(posedge clock);
      #1;
      tests_run++;
      if ({wr_en, wr_sec, wr_idx, wr_data} !== 41'd0) begin
         tests_failed++;
         $display("[TB] FAIL reset_wr_port: got %h expected 0", {wr_en, wr_sec, wr_idx, wr_data});
      end
      tests_run++;
      if ({busy, done, error} !== 3'b000) begin
         tests_failed++;
         $display("[TB] FAIL reset_flags: got %b expected 000", {busy, done, error});
      end
   endtask

   task automatic test_pc_and_regs();
      int base;
      logic [31:0] w;
      pulse_start();
      base = cnt_main;
      send_byte(8'h78, 1); send_byte(8'h56, 1); send_byte(8'h34, 1); send_byte(8'h12, 1);
      tests_run++;
      if (cnt_main !== base + 1 || last_sec !== 2'd0 || last_idx !== 6'd0 || last_data !== 32'h12345678) begin
         tests_failed++;
         $display("[TB] FAIL pc_word: got n=%0d sec=%0d idx=%0d data=%h expected n=%0d sec=0 idx=0 data=12345678",
                  cnt_main - base, last_sec, last_idx, last_data, 1);
      end
      for (int wi = 0; wi < 32; wi++) begin
         w = {8'(4*wi+3), 8'(4*wi+2), 8'(4*wi+1), 8'(4*wi)};
         send_word(w, 1);
         tests_run++;
         if (cnt_main !== base + 2 + wi || last_sec !== 2'd1 || last_idx !== 6'(wi) || last_data !== w) begin
            tests_failed++;
            $display("[TB] FAIL reg_word[%0d]: got sec=%0d idx=%0d data=%h expected sec=1 idx=%0d data=%h",
                     wi, last_sec, last_idx, last_data, wi, w);
         end
      end
   endtask

   task automatic test_full_dump();
      logic [31:0] w;
      for (int wi = 0; wi < 32; wi++) begin
         w = 32'hA000_0000 + 32'(wi);
         send_word(w, 1);
         tests_run++;
         if (last_sec !== 2'd2 || last_idx !== 6'(wi) || last_data !== w) begin
            tests_failed++;
            $display("[TB] FAIL mem_word[%0d]: got sec=%0d idx=%0d data=%h expected sec=2 idx=%0d data=%h",
                     wi, last_sec, last_idx, last_data, wi, w);
         end
      end
      tests_run++;
      if (cnt_main !== 65) begin
         tests_failed++;
         $display("[TB] FAIL dump_strobes: got %0d expected 65", cnt_main);
      end
      tests_run++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL dump_done: got done=%b busy=%b expected done=1 busy=0", done, busy);
      end
      send_word(32'hDEADBEEF, 1);
      tests_run++;
      if (cnt_main !== 65 || done !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL done_ignores_bytes: got n=%0d done=%b expected n=65 done=1", cnt_main, done);
      end
   endtask

   task automatic test_held_rx_done();
      int base;
      pulse_start();
      base = cnt_main;
      send_word(32'h44332211, 5);
      tests_run++;
      if (cnt_main !== base + 1 || last_data !== 32'h44332211 || last_sec !== 2'd0) begin
         tests_failed++;
         $display("[TB] FAIL held_rx_done: got n=%0d data=%h sec=%0d expected n=1 data=44332211 sec=0",
                  cnt_main - base, last_data, last_sec);
      end
   endtask

   task automatic test_timeout();
      int n;
      int base;
      pulse_start();
      base = cnt_to;
      send_byte(8'h01, 1);
      send_byte(8'h02, 1);
      n = 1;
      while (error_to !== 1'b1 && n < 300) begin
         @(posedge clock);
         #1;
         n++;
      end
      tests_run++;
      if (n !== 100) begin
         tests_failed++;
         $display("[TB] FAIL timeout_cycle: got %0d expected 100", n);
      end
      tests_run++;
      if (busy_to !== 1'b0 || done_to !== 1'b0 || cnt_to !== base) begin
         tests_failed++;
         $display("[TB] FAIL timeout_idle: got busy=%b done=%b strobes=%0d expected 0 0 0",
                  busy_to, done_to, cnt_to - base);
      end
      pulse_start();
      tests_run++;
      if (error_to !== 1'b0 || busy_to !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL timeout_clear: got error=%b busy=%b expected error=0 busy=1", error_to, busy_to);
      end
   endtask

   task automatic test_abort();
      int base;
      pulse_start();
      base = cnt_main;
      send_byte(8'h11, 1); send_byte(8'h22, 1); send_byte(8'h33, 1);
      pulse_abort();
      tests_run++;
      if (busy !== 1'b0 || cnt_main !== base) begin
         tests_failed++;
         $display("[TB] FAIL abort_idle: got busy=%b strobes=%0d expected busy=0 strobes=0", busy, cnt_main - base);
      end
      pulse_start();
      send_word(32'hDDCCBBAA, 1);
      tests_run++;
      if (cnt_main !== base + 1 || last_data !== 32'hDDCCBBAA || last_idx !== 6'd0 || last_sec !== 2'd0) begin
         tests_failed++;
         $display("[TB] FAIL abort_restart: got n=%0d data=%h idx=%0d sec=%0d expected n=1 data=DDCCBBAA idx=0 sec=0",
                  cnt_main - base, last_data, last_idx, last_sec);
      end
   endtask

   task automatic test_reg_only();
      int base;
      pulse_start();
      base = cnt_s;
      send_word(32'h0000_0001, 1);
      tests_run++;
      if (cnt_s !== base + 1 || last_sec_s !== 2'd1 || last_idx_s !== 2'd0) begin
         tests_failed++;
         $display("[TB] FAIL reg_only_w0: got n=%0d sec=%0d idx=%0d expected n=1 sec=1 idx=0",
                  cnt_s - base, last_sec_s, last_idx_s);
      end
      send_word(32'h0000_0002, 1);
      tests_run++;
      if (cnt_s !== base + 2 || last_sec_s !== 2'd1 || last_idx_s !== 2'd1 || wr_data_s !== 32'h2) begin
         tests_failed++;
         $display("[TB] FAIL reg_only_w1: got n=%0d sec=%0d idx=%0d data=%h expected n=2 sec=1 idx=1 data=2",
                  cnt_s - base, last_sec_s, last_idx_s, wr_data_s);
      end
      tests_run++;
      if (done_s !== 1'b1 || busy_s !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL reg_only_done: got done=%b busy=%b expected done=1 busy=0", done_s, busy_s);
      end
   endtask

   task automatic test_async_reset();
      int base;
      send_byte(8'h55, 1);
      send_byte(8'h66, 1);
      tests_run++;
      if (busy !== 1'b1 || wr_data === 32'd0) begin
         tests_failed++;
         $display("[TB] FAIL pre_reset_state: got busy=%b data=%h expected busy=1 data nonzero", busy, wr_data);
      end
      #2 reset_n = 1'b0;
      #1;
      tests_run++;
      if ({wr_en, wr_sec, wr_idx, wr_data, busy, done, error} !== 44'd0) begin
         tests_failed++;
         $display("[TB] FAIL async_reset: got %h expected 0", {wr_en, wr_sec, wr_idx, wr_data, busy, done, error});
      end
      @(posedge clock);
      #1 reset_n = 1'b1;
      @(posedge clock);
      #1;
      pulse_start();
      base = cnt_main;
      send_word(32'h04030201, 1);
      tests_run++;
      if (cnt_main !== base + 1 || last_data !== 32'h04030201 || last_sec !== 2'd0) begin
         tests_failed++;
         $display("[TB] FAIL post_reset_word: got n=%0d data=%h sec=%0d expected n=1 data=04030201 sec=0",
                  cnt_main - base, last_data, last_sec);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      cnt_main     = 0;
      cnt_to       = 0;
      cnt_s        = 0;
      last_sec     = '0;
      last_idx     = '0;
      last_data    = '0;
      last_sec_s   = '0;
      last_idx_s   = '0;
      reset_n      = 1'b0;
      start        = 1'b0;
      abort        = 1'b0;
      rx_done      = 1'b0;
      rx_data      = 8'h00;
      #1;
      test_reset();
      test_pc_and_regs();
      test_full_dump();
      test_held_rx_done();
      test_timeout();
      test_abort();
      test_reg_only();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
